rgbw_frame_decoder: RTL and testbench

Byte-stream frame decoder sitting directly downstream of the SPI slave receiver. Consumes the received bytes and their ready strobe, parses command frames, and drives the shadowed colour/intensity registers consumed by the PWM/colour-mixing stage. Only complete, valid frames update the outputs, and each update is signalled with a single-cycle strobe. Partial, aborted, timed-out or malformed frames are discarded and flagged.

---
 rtl/rgbw_frame_decoder_pkg.sv | 34 +++
 rtl/rgbw_frame_decoder_if.sv | 13 +
 rtl/rgbw_frame_decoder_edge.sv | 18 +
 rtl/rgbw_frame_decoder.sv | 179 +++++++++++++++++
 tb/tb_rgbw_frame_decoder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rgbw_frame_decoder_pkg.sv
// rgbw_pkg: shared constants and types for the RGBW frame decoder.
//   - command byte codes and their data-byte counts
//   - FSM state encoding (CHK exists only when FRAME_CHECKSUM_EN is defined)
//   - cmd_len(): data-byte count for a command, 0 for an unknown command
package rgbw_pkg;

  localparam logic [7:0] CMD_SET_RGBW = 8'h01;
  localparam logic [7:0] CMD_SET_INT  = 8'h02;
  localparam logic [7:0] CMD_SET_ALL  = 8'h03;

  localparam logic [2:0] LEN_RGBW = 3'd4;
  localparam logic [2:0] LEN_INT  = 3'd1;
  localparam logic [2:0] LEN_ALL  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
`ifdef FRAME_CHECKSUM_EN
    CHK     = 3'd2,
`endif
    COMMIT  = 3'd3,
    DISCARD = 3'd4
  } state_t;

  function automatic logic [2:0] cmd_len(input logic [7:0] cmd);
    case (cmd)
      CMD_SET_RGBW: cmd_len = LEN_RGBW;
      CMD_SET_INT:  cmd_len = LEN_INT;
      CMD_SET_ALL:  cmd_len = LEN_ALL;
      default:      cmd_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rgbw_frame_decoder_if.sv
// rgbw_frame_decoder_if: byte stream from the SPI slave receiver.
//   cs        - chip select, active-low (high = bus idle)
//   byte_rdy  - byte-valid level, may be held for several cycles
//   byte_data - received byte, stable while byte_rdy is high
// master = SPI receiver side, slave = frame decoder side.
interface rgbw_frame_decoder_if;
  logic       cs;
  logic       byte_rdy;
  logic [7:0] byte_data;

  modport master (output cs, output byte_rdy, output byte_data);
  modport slave  (input  cs, input  byte_rdy, input  byte_data);
endinterface

// File: rtl/rgbw_frame_decoder_edge.sv
// byte_edge_detect: turns the byte_rdy level into a one-cycle accept strobe
// on its rising edge so a held level consumes a byte only once.
//   clk, reset (sync, active-high), byte_rdy in; accept out.
module byte_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic byte_rdy,
  output logic accept
);
  logic rdy_q;

  always_ff @(posedge clk) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= byte_rdy;
  end

  assign accept = byte_rdy & ~rdy_q;
endmodule

// File: rtl/rgbw_frame_decoder.sv
// rgbw_frame_decoder: parses command frames from the SPI byte stream and
// drives the committed colour/intensity registers.
//   clk, reset           - clock, synchronous active-high reset
//   bus (slave modport)  - cs, byte_rdy, byte_data
//   red/green/blue/white - committed colour channels
//   intensity            - committed master intensity
//   update               - one-cycle pulse when outputs were committed
//   frame_err            - one-cycle pulse when a frame was discarded
// Build option: define FRAME_CHECKSUM_EN to require a trailing XOR byte.
//
// state   | meaning
// IDLE    | waiting for a command byte
// DATA    | collecting data bytes into shadow
// CHK     | waiting for the checksum byte (FRAME_CHECKSUM_EN only)
// COMMIT  | copy shadow to outputs, pulse update
// DISCARD | ignore bytes until cs goes high
module rgbw_frame_decoder
  import rgbw_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] INTENSITY_RST  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  rgbw_frame_decoder_if.slave  bus,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic [7:0]           white,
  output logic [7:0]           intensity,
  output logic                 update,
  output logic                 frame_err
);
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic             accept, take;
  logic [7:0]       cmd_q;
  logic [2:0]       need, idx;
  logic [7:0]       shadow [5];
  logic [GAP_W-1:0] gap;
  logic             in_frame, last_byte, timeout;
  logic             commit_now, err_now;
  logic [2:0]       new_len;

  byte_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .byte_rdy (bus.byte_rdy),
    .accept   (accept)
  );

  // cs high wins over a coincident byte edge
  assign take      = accept & ~bus.cs;
  assign new_len   = cmd_len(bus.byte_data);
  assign last_byte = (idx == need - 3'd1);

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  assign csum_ok  = (bus.byte_data == csum);
  assign in_frame = (state == DATA) || (state == CHK);
`else
  assign in_frame = (state == DATA);
`endif

  // a byte arriving on the terminal count wins over the timeout
  assign timeout = in_frame && (gap == GAP_LAST) && !take;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.cs) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (take) next_state = (new_len != 3'd0) ? DATA : DISCARD;
`ifdef FRAME_CHECKSUM_EN
        DATA:    if (take && last_byte) next_state = CHK;
                 else if (timeout)      next_state = IDLE;
        CHK:     if (take)              next_state = csum_ok ? COMMIT : DISCARD;
                 else if (timeout)      next_state = IDLE;
`else
        DATA:    if (take && last_byte) next_state = COMMIT;
                 else if (timeout)      next_state = IDLE;
`endif
        COMMIT:  next_state = IDLE;
        DISCARD: next_state = DISCARD;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    commit_now = (state == COMMIT) && !bus.cs;
    err_now    = 1'b0;
    if (bus.cs) begin
      err_now = in_frame;
    end else begin
      case (state)
        IDLE:    err_now = take && (new_len == 3'd0);
        DATA:    err_now = timeout;
`ifdef FRAME_CHECKSUM_EN
        CHK:     err_now = (take && !csum_ok) || timeout;
`endif
        default: err_now = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
      white     <= 8'h00;
      intensity <= INTENSITY_RST;
      update    <= 1'b0;
      frame_err <= 1'b0;
      cmd_q     <= 8'h00;
      need      <= 3'd0;
      idx       <= 3'd0;
      gap       <= '0;
      for (int i = 0; i < 5; i++) shadow[i] <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      update    <= commit_now;
      frame_err <= err_now;

      if (state == IDLE && take && new_len != 3'd0) begin
        cmd_q <= bus.byte_data;
        need  <= new_len;
        idx   <= 3'd0;
`ifdef FRAME_CHECKSUM_EN
        csum  <= bus.byte_data;
`endif
      end

      if (state == DATA && take) begin
        shadow[idx] <= bus.byte_data;
        idx         <= idx + 3'd1;
`ifdef FRAME_CHECKSUM_EN
        csum        <= csum ^ bus.byte_data;
`endif
      end

      // saturating gap counter, live only inside a frame
      if (take || !in_frame) gap <= '0;
      else if (gap != GAP_LAST) gap <= gap + 1'b1;

      if (commit_now) begin
        case (cmd_q)
          CMD_SET_RGBW: begin
            red   <= shadow[0];
            green <= shadow[1];
            blue  <= shadow[2];
            white <= shadow[3];
          end
          CMD_SET_INT: intensity <= shadow[0];
          CMD_SET_ALL: begin
            red       <= shadow[0];
            green     <= shadow[1];
            blue      <= shadow[2];
            white     <= shadow[3];
            intensity <= shadow[4];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rgbw_frame_decoder.sv
module tb_rgbw_frame_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] red, green, blue, white, intensity;
  logic       update, frame_err;

  rgbw_frame_decoder_if bus ();

  rgbw_frame_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .white     (white),
    .intensity (intensity),
    .update    (update),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0, err_cnt = 0, upd_long = 0;
  logic prev_upd = 1'b0;

  always @(negedge clk) begin
    if (update) upd_cnt++;
    if (frame_err) err_cnt++;
    if (update && prev_upd) upd_long++;
    prev_upd = update;
  end

  typedef struct {
    logic [0:5][7:0] b;
    int              n;
    int              hold;
    bit              full;
    logic [7:0]      er, eg, eb, ew, ei;
    int              eupd;
    int              eerr;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [47:0] bb, input int n, input int hold,
                              input bit full, input logic [39:0] exp_out,
                              input int eupd, input int eerr);
    vec_t v;
    v.b = bb; v.n = n; v.hold = hold; v.full = full;
    v.er = exp_out[39:32]; v.eg = exp_out[31:24]; v.eb = exp_out[23:16];
    v.ew = exp_out[15:8];  v.ei = exp_out[7:0];
    v.eupd = eupd; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    bus.byte_data = b;
    bus.byte_rdy  = 1'b1;
    cyc(hold);
    bus.byte_rdy  = 1'b0;
    cyc(1);
  endtask

  task automatic send_frame2(input logic [7:0] c, input logic [7:0] d);
    send_byte(c, 1);
    send_byte(d, 1);
`ifdef FRAME_CHECKSUM_EN
    send_byte(c ^ d, 1);
`endif
  endtask

  task automatic chk_outs(input string tag, input logic [39:0] e);
    chk({tag, ".red"},       32'(red),       32'(e[39:32]));
    chk({tag, ".green"},     32'(green),     32'(e[31:24]));
    chk({tag, ".blue"},      32'(blue),      32'(e[23:16]));
    chk({tag, ".white"},     32'(white),     32'(e[15:8]));
    chk({tag, ".intensity"}, 32'(intensity), 32'(e[7:0]));
  endtask

  initial begin
    int u0, e0, n;
    logic [7:0] x;

    vecs[0] = mk(48'h01_10_20_30_40_00, 5, 1, 1, 40'h10_20_30_40_FF, 1, 0);
    vecs[1] = mk(48'h02_7F_00_00_00_00, 2, 2, 1, 40'h10_20_30_40_7F, 1, 0);
    vecs[2] = mk(48'h55_11_22_00_00_00, 3, 1, 0, 40'h10_20_30_40_7F, 0, 1);
    vecs[3] = mk(48'h02_01_00_00_00_00, 2, 1, 1, 40'h10_20_30_40_01, 1, 0);
    vecs[4] = mk(48'h03_A1_A2_A3_A4_A5, 6, 3, 1, 40'hA1_A2_A3_A4_A5, 1, 0);
    vecs[5] = mk(48'h03_B1_B2_B3_00_00, 4, 1, 0, 40'hA1_A2_A3_A4_A5, 0, 1);
    vecs[6] = mk(48'h03_01_02_03_04_05, 6, 1, 1, 40'h01_02_03_04_05, 1, 0);
    vecs[7] = mk(48'h01_C0_C1_C2_C3_00, 5, 2, 1, 40'hC0_C1_C2_C3_05, 1, 0);

    reset = 1'b1;
    bus.cs = 1'b1;
    bus.byte_rdy = 1'b0;
    bus.byte_data = 8'h00;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    chk_outs("reset", 40'h00_00_00_00_FF);
    chk("reset.update",    32'(update),    32'd0);
    chk("reset.frame_err", 32'(frame_err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      u0 = upd_cnt; e0 = err_cnt;
      bus.cs = 1'b0;
      cyc(2);
      x = 8'h00;
      for (int k = 0; k < vecs[i].n; k++) begin
        send_byte(vecs[i].b[k], vecs[i].hold);
        x ^= vecs[i].b[k];
      end
`ifdef FRAME_CHECKSUM_EN
      if (vecs[i].full) send_byte(x, vecs[i].hold);
`endif
      cyc(3);
      bus.cs = 1'b1;
      cyc(3);
      chk_outs($sformatf("vec%0d", i), {vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].ew, vecs[i].ei});
      chk($sformatf("vec%0d.update_pulses", i), 32'(upd_cnt - u0), 32'(vecs[i].eupd));
      chk($sformatf("vec%0d.err_pulses", i),    32'(err_cnt - e0), 32'(vecs[i].eerr));
    end
    chk("update_width", 32'(upd_long), 32'd0);

    // timeout: 0x01,0xAA then silence
    u0 = upd_cnt; e0 = err_cnt;
    bus.cs = 1'b0;
    cyc(2);
    send_byte(8'h01, 1);
    send_byte(8'hAA, 1);
    n = 0;
    while (!frame_err && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout.latency", 32'(n), 32'd4095);
    cyc(2);
    chk("timeout.err_pulses", 32'(err_cnt - e0), 32'd1);
    send_frame2(8'h02, 8'h44);
    cyc(3);
    bus.cs = 1'b1;
    cyc(3);
    chk("timeout.next_frame", 32'(intensity), 32'h44);
    chk("timeout.upd_pulses", 32'(upd_cnt - u0), 32'd1);
    chk("timeout.red_kept",   32'(red),       32'hC0);

    // two frames back to back under one cs
    u0 = upd_cnt;
    bus.cs = 1'b0;
    cyc(2);
    send_frame2(8'h02, 8'h05);
    send_frame2(8'h02, 8'h06);
    cyc(3);
    bus.cs = 1'b1;
    cyc(3);
    chk("b2b.intensity", 32'(intensity), 32'h06);
    chk("b2b.upd_pulses", 32'(upd_cnt - u0), 32'd2);

    // cs rising together with a byte edge inside a frame
    u0 = upd_cnt; e0 = err_cnt;
    bus.cs = 1'b0;
    cyc(2);
    send_byte(8'h02, 1);
    bus.cs = 1'b1;
    bus.byte_data = 8'h99;
    bus.byte_rdy = 1'b1;
    cyc(1);
    bus.byte_rdy = 1'b0;
    cyc(4);
    chk("cs_edge.intensity", 32'(intensity), 32'h06);
    chk("cs_edge.err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("cs_edge.upd_pulses", 32'(upd_cnt - u0), 32'd0);

`ifdef FRAME_CHECKSUM_EN
    u0 = upd_cnt; e0 = err_cnt;
    bus.cs = 1'b0;
    cyc(2);
    send_byte(8'h02, 1);
    send_byte(8'h33, 1);
    send_byte(8'h31, 1);
    cyc(3);
    bus.cs = 1'b1;
    cyc(3);
    chk("csum_good.intensity", 32'(intensity), 32'h33);
    bus.cs = 1'b0;
    cyc(2);
    send_byte(8'h02, 1);
    send_byte(8'h44, 1);
    send_byte(8'h30, 1);
    cyc(3);
    bus.cs = 1'b1;
    cyc(3);
    chk("csum_bad.intensity", 32'(intensity), 32'h33);
    chk("csum.err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("csum.upd_pulses", 32'(upd_cnt - u0), 32'd1);
`endif

    // reset lands in the COMMIT cycle
    u0 = upd_cnt;
    bus.cs = 1'b0;
    cyc(2);
    send_byte(8'h02, 1);
`ifdef FRAME_CHECKSUM_EN
    send_byte(8'h12, 1);
    bus.byte_data = 8'h10;
`else
    bus.byte_data = 8'h12;
`endif
    bus.byte_rdy = 1'b1;
    cyc(1);
    reset = 1'b1;
    bus.byte_rdy = 1'b0;
    cyc(1);
    reset = 1'b0;
    bus.cs = 1'b1;
    cyc(3);
    chk_outs("rst_commit", 40'h00_00_00_00_FF);
    chk("rst_commit.upd_pulses", 32'(upd_cnt - u0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
